iec_sd_arbiter: RTL and testbench

//  Downstream of the multi-drive IEC selector: funnels the NDR per-drive SD

---
 rtl/iec_sd_arbiter_pkg.sv | 34 +++
 rtl/iec_sd_arbiter_rr_pick.sv | 28 ++
 rtl/iec_sd_arbiter.sv | 164 ++++++++++++++++
 tb/tb_iec_sd_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iec_sd_arbiter_pkg.sv
// Shared types and elaboration helpers for the IEC SD request arbiter.
// Used by iec_sd_arbiter and iec_rr_pick.
package iec_sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    REL  = 2'd3
  } arb_state_t;

  localparam int MAX_DRIVES = 4;

  // Keeps any requested drive count within what the host port can serve.
  function automatic int ndr_clamp(input int drives);
    if (drives < 1) begin
      return 1;
    end else if (drives > MAX_DRIVES) begin
      return MAX_DRIVES;
    end else begin
      return drives;
    end
  endfunction

  // Width of a drive index; a single drive still needs one bit.
  function automatic int idx_w(input int ndr);
    if (ndr > 1) begin
      return $clog2(ndr);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/iec_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping from the highest drive back to drive 0.
module iec_rr_pick
  import iec_sd_pkg::*;
#(
  parameter int NDR = 2,
  localparam int IW = idx_w(NDR)
) (
  input  logic [NDR-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic           valid,
  output logic [IW-1:0]  idx
);

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    int cand;
    cand  = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NDR - 1; k >= 0; k--) begin
      cand  = (int'(ptr) + k) % NDR;
      idx   = req[cand] ? cand[IW-1:0] : idx;
      valid = valid | req[cand];
    end
  end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Funnels per-drive SD sector requests onto one host SD port (round-robin).
// Optional grant-to-ack watchdog: define IEC_SD_ARB_TIMEOUT_EN.
module iec_sd_arbiter
  import iec_sd_pkg::*;
#(
  parameter int DRIVES      = 2,
  parameter int TIMEOUT_CYC = 2**24,
  localparam int NDR = ndr_clamp(DRIVES),
  localparam int IW  = idx_w(NDR)
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [31:0]    sd_lba [NDR],
  input  logic [5:0]     sd_blk_cnt [NDR],
  input  logic [NDR-1:0] sd_rd,
  input  logic [NDR-1:0] sd_wr,
  output logic [NDR-1:0] sd_ack,
  input  logic [7:0]     sd_buff_din [NDR],
  output logic [31:0]    host_lba,
  output logic [5:0]     host_blk_cnt,
  output logic           host_rd,
  output logic           host_wr,
  input  logic           host_ack,
  output logic [7:0]     host_buff_din,
  output logic           busy,
  output logic           timeout_err
);

  arb_state_t     state_r;
  logic [IW-1:0]  grant_r;
  logic [IW-1:0]  ptr_r;
  logic [31:0]    host_lba_r;
  logic [5:0]     host_blk_cnt_r;
  logic           host_rd_r;
  logic           host_wr_r;
  logic [NDR-1:0] req_s;
  logic           pick_valid_s;
  logic [IW-1:0]  pick_idx_s;

`ifdef IEC_SD_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_err_r;
`endif

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    if (int'(g) >= NDR - 1) begin
      return '0;
    end else begin
      return g + IW'(1);
    end
  endfunction

  // A drive is requesting while either of its level request lines is high.
  always_comb begin
    req_s = sd_rd | sd_wr;
  end

  iec_rr_pick #(.NDR(NDR)) u_rr_pick (
    .req   (req_s),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Arbitration FSM with registered host-side request outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r        <= IDLE;
      grant_r        <= '0;
      ptr_r          <= '0;
      host_lba_r     <= 32'd0;
      host_blk_cnt_r <= 6'd0;
      host_rd_r      <= 1'b0;
      host_wr_r      <= 1'b0;
`ifdef IEC_SD_ARB_TIMEOUT_EN
      to_cnt_r       <= '0;
      timeout_err_r  <= 1'b0;
`endif
    end else begin
`ifdef IEC_SD_ARB_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r        <= pick_idx_s;
            host_lba_r     <= sd_lba[pick_idx_s];
            host_blk_cnt_r <= sd_blk_cnt[pick_idx_s];
            // Read wins when a drive raises both lines.
            host_rd_r      <= sd_rd[pick_idx_s];
            host_wr_r      <= ~sd_rd[pick_idx_s] & sd_wr[pick_idx_s];
            state_r        <= REQ;
`ifdef IEC_SD_ARB_TIMEOUT_EN
            to_cnt_r       <= '0;
`endif
          end
        end
        REQ: begin
          if (!req_s[grant_r]) begin
            host_rd_r <= 1'b0;
            host_wr_r <= 1'b0;
            ptr_r     <= next_ptr(grant_r);
            state_r   <= IDLE;
          end else if (host_ack) begin
            host_rd_r <= 1'b0;
            host_wr_r <= 1'b0;
            state_r   <= BUSY;
          end
`ifdef IEC_SD_ARB_TIMEOUT_EN
          else if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
            host_rd_r     <= 1'b0;
            host_wr_r     <= 1'b0;
            timeout_err_r <= 1'b1;
            ptr_r         <= next_ptr(grant_r);
            state_r       <= REL;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
`endif
        end
        BUSY: begin
          if (!host_ack) begin
            state_r <= REL;
          end
        end
        REL: begin
          // Hold off the next grant until the drive has seen its ack end.
          if (!req_s[grant_r]) begin
            ptr_r   <= next_ptr(grant_r);
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Ack reaches only the granted drive, and only while the transfer is live.
  always_comb begin
    sd_ack = '0;
    if (state_r == BUSY) begin
      sd_ack[grant_r] = host_ack;
    end else begin
      sd_ack = '0;
    end
  end

  assign host_buff_din = sd_buff_din[grant_r];
  assign host_lba      = host_lba_r;
  assign host_blk_cnt  = host_blk_cnt_r;
  assign host_rd       = host_rd_r;
  assign host_wr       = host_wr_r;
  assign busy          = (state_r != IDLE);

`ifdef IEC_SD_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Directed self-checking bench for iec_sd_arbiter with two drives.
// The watchdog scenario runs only when IEC_SD_ARB_TIMEOUT_EN is defined.
module tb_iec_sd_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] sd_lba [2];
  logic [5:0]  sd_blk_cnt [2];
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic [1:0]  sd_ack;
  logic [7:0]  sd_buff_din [2];
  logic [31:0] host_lba;
  logic [5:0]  host_blk_cnt;
  logic        host_rd;
  logic        host_wr;
  logic        host_ack;
  logic [7:0]  host_buff_din;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  iec_sd_arbiter #(.DRIVES(2), .TIMEOUT_CYC(16)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .sd_lba        (sd_lba),
    .sd_blk_cnt    (sd_blk_cnt),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_buff_din   (sd_buff_din),
    .host_lba      (host_lba),
    .host_blk_cnt  (host_blk_cnt),
    .host_rd       (host_rd),
    .host_wr       (host_wr),
    .host_ack      (host_ack),
    .host_buff_din (host_buff_din),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sd_rd = 2'b00; sd_wr = 2'b00; host_ack = 1'b0;
    sd_lba[0] = 32'd0; sd_lba[1] = 32'd0;
    sd_blk_cnt[0] = 6'd0; sd_blk_cnt[1] = 6'd0;
    sd_buff_din[0] = 8'd0; sd_buff_din[1] = 8'd0;
    do_reset();
    total++;
    if ({host_rd, host_wr, busy, timeout_err, sd_ack} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl got rd=%b wr=%b busy=%b to=%b ack=%b want all 0",
               host_rd, host_wr, busy, timeout_err, sd_ack);
    end
    total++;
    if (host_lba !== 32'd0 || host_blk_cnt !== 6'd0) begin
      bad++;
      $display("FAIL reset_lba got lba=%h cnt=%0d want 0/0", host_lba, host_blk_cnt);
    end
  endtask

  task automatic test_basic_read();
    int ack_ok;
    sd_lba[0] = 32'h123;
    sd_rd = 2'b01;
    tick();
    total++;
    if (host_rd !== 1'b1 || host_wr !== 1'b0 || host_lba !== 32'h123 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_grant got rd=%b wr=%b lba=%h busy=%b want 1 0 123 1",
               host_rd, host_wr, host_lba, busy);
    end
    host_ack = 1'b1;
    #1;
    total++;
    if (sd_ack !== 2'b00) begin
      bad++;
      $display("FAIL basic_req_ack got %b want 00", sd_ack);
    end
    tick();
    total++;
    if (host_rd !== 1'b0) begin
      bad++;
      $display("FAIL basic_rd_drop got %b want 0", host_rd);
    end
    ack_ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (sd_ack === 2'b01) ack_ok++;
      tick();
    end
    total++;
    if (ack_ok !== 10) begin
      bad++;
      $display("FAIL basic_ack_cycles got %0d want 10", ack_ok);
    end
    host_ack = 1'b0;
    #1;
    total++;
    if (sd_ack !== 2'b00) begin
      bad++;
      $display("FAIL basic_ack_fall got %b want 00", sd_ack);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_rel_hold got busy=%b want 1", busy);
    end
    sd_rd = 2'b00;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    sd_lba[0] = 32'hA0; sd_lba[1] = 32'hB1;
    sd_rd = 2'b11;
    tick();
    total++;
    if (host_lba !== 32'hA0) begin
      bad++;
      $display("FAIL rr_first got lba=%h want a0", host_lba);
    end
    host_ack = 1'b1; tick();
    host_ack = 1'b0; tick();
    sd_rd = 2'b10; tick();
    sd_rd = 2'b11; tick();
    total++;
    if (host_lba !== 32'hB1 || host_rd !== 1'b1) begin
      bad++;
      $display("FAIL rr_second got lba=%h rd=%b want b1 1", host_lba, host_rd);
    end
    host_ack = 1'b1; tick();
    total++;
    if (sd_ack !== 2'b10) begin
      bad++;
      $display("FAIL rr_ack1 got %b want 10", sd_ack);
    end
    host_ack = 1'b0; tick();
    sd_rd = 2'b01; tick();
    tick();
    total++;
    if (host_lba !== 32'hA0 || host_rd !== 1'b1) begin
      bad++;
      $display("FAIL rr_third got lba=%h rd=%b want a0 1", host_lba, host_rd);
    end
    sd_rd = 2'b00; tick();
  endtask

  task automatic test_write_mux();
    sd_lba[1] = 32'h55; sd_blk_cnt[1] = 6'd3;
    sd_wr = 2'b10;
    tick();
    total++;
    if (host_wr !== 1'b1 || host_rd !== 1'b0 || host_blk_cnt !== 6'd3 || host_lba !== 32'h55) begin
      bad++;
      $display("FAIL wr_grant got wr=%b rd=%b cnt=%0d lba=%h want 1 0 3 55",
               host_wr, host_rd, host_blk_cnt, host_lba);
    end
    host_ack = 1'b1; tick();
    sd_buff_din[1] = 8'h3C; sd_buff_din[0] = 8'hFF;
    #1;
    total++;
    if (host_buff_din !== 8'h3C) begin
      bad++;
      $display("FAIL wr_din got %h want 3c", host_buff_din);
    end
    sd_buff_din[0] = 8'h00;
    #1;
    sd_buff_din[1] = 8'hC3;
    #1;
    total++;
    if (host_buff_din !== 8'hC3) begin
      bad++;
      $display("FAIL wr_din_track got %h want c3", host_buff_din);
    end
    host_ack = 1'b0; tick();
    sd_wr = 2'b00; tick();
    sd_rd = 2'b01; sd_wr = 2'b01;
    tick();
    total++;
    if (host_rd !== 1'b1 || host_wr !== 1'b0 || host_blk_cnt !== 6'd0) begin
      bad++;
      $display("FAIL rdwr_both got rd=%b wr=%b cnt=%0d want 1 0 0", host_rd, host_wr, host_blk_cnt);
    end
    sd_rd = 2'b00; sd_wr = 2'b00; tick();
  endtask

  task automatic test_cancel();
    sd_rd = 2'b01;
    tick();
    total++;
    if (host_rd !== 1'b1) begin
      bad++;
      $display("FAIL cancel_grant got rd=%b want 1", host_rd);
    end
    sd_rd = 2'b00;
    tick();
    total++;
    if (host_rd !== 1'b0 || busy !== 1'b0 || sd_ack !== 2'b00) begin
      bad++;
      $display("FAIL cancel_drop got rd=%b busy=%b ack=%b want 0 0 00", host_rd, busy, sd_ack);
    end
    host_ack = 1'b1;
    #1;
    total++;
    if (sd_ack !== 2'b00) begin
      bad++;
      $display("FAIL cancel_ack_idle got %b want 00", sd_ack);
    end
    tick();
    total++;
    if (sd_ack !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cancel_ack_late got ack=%b busy=%b want 00 0", sd_ack, busy);
    end
    host_ack = 1'b0;
  endtask

  task automatic test_reset_busy();
    sd_lba[0] = 32'h66; sd_lba[1] = 32'h77;
    sd_rd = 2'b10;
    tick();
    host_ack = 1'b1; tick();
    total++;
    if (sd_ack !== 2'b10) begin
      bad++;
      $display("FAIL rstbusy_pre got %b want 10", sd_ack);
    end
    sd_buff_din[0] = 8'h00; sd_buff_din[1] = 8'h00;
    reset = 1'b1;
    tick();
    total++;
    if ({host_rd, host_wr, busy, timeout_err, sd_ack, host_buff_din} !== 14'b0 ||
        host_lba !== 32'd0 || host_blk_cnt !== 6'd0) begin
      bad++;
      $display("FAIL rstbusy_out got rd=%b wr=%b busy=%b ack=%b lba=%h want all 0",
               host_rd, host_wr, busy, sd_ack, host_lba);
    end
    reset = 1'b0; host_ack = 1'b0;
    sd_rd = 2'b11;
    tick();
    total++;
    if (host_lba !== 32'h66) begin
      bad++;
      $display("FAIL rstbusy_ptr got lba=%h want 66", host_lba);
    end
    sd_rd = 2'b00; tick();
  endtask

`ifdef IEC_SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    do_reset();
    sd_lba[0] = 32'hC0; sd_lba[1] = 32'hC1;
    sd_rd = 2'b11;
    tick();
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (timeout_err !== 1'b0) early++;
    end
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL to_early got %0d pulses want 0", early);
    end
    tick();
    total++;
    if (timeout_err !== 1'b1 || host_rd !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL to_pulse got to=%b rd=%b busy=%b want 1 0 1", timeout_err, host_rd, busy);
    end
    sd_rd = 2'b10;
    tick();
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_width got %b want 0", timeout_err);
    end
    tick();
    total++;
    if (host_lba !== 32'hC1 || host_rd !== 1'b1) begin
      bad++;
      $display("FAIL to_next got lba=%h rd=%b want c1 1", host_lba, host_rd);
    end
    sd_rd = 2'b00; tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic_read();
    test_round_robin();
    test_write_mux();
    test_cancel();
    test_reset_busy();
`ifdef IEC_SD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
